// File: rtl/udma_l2_arb_pkg.sv
// Shared types and default widths for the uDMA L2 port arbiter.
package udma_l2_arb_pkg;

  typedef enum logic {SRC_RO = 1'b0, SRC_WO = 1'b1} l2_src_e;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_STAT_WIDTH      = 16;

  function automatic l2_src_e other_src(input l2_src_e src);
    return (src == SRC_RO) ? SRC_WO : SRC_RO;
  endfunction

endpackage

// File: rtl/udma_l2_arb_src_fifo.sv
// 1-bit source-tracking FIFO: remembers which port owns each outstanding L2 transaction.
module udma_l2_arb_src_fifo
  import udma_l2_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (cnt_r == (PW+1)'(DEPTH));
  assign empty     = (cnt_r == {(PW+1){1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, wrap-around pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/udma_l2_arbiter.sv
// Round-robin arbiter merging the uDMA RO and WO TCDM ports onto one L2 master port.
// Optional statistics counters are enabled by defining UDMA_L2_ARB_STATS_EN.
module udma_l2_arbiter
  import udma_l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned STAT_WIDTH      = DEF_STAT_WIDTH
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_resetn_i,
  input  logic                    ro_req_i,
  input  logic                    ro_wen_i,
  input  logic [ADDR_WIDTH-1:0]   ro_addr_i,
  input  logic [DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                    ro_gnt_o,
  output logic                    ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ro_rdata_o,
  input  logic                    wo_req_i,
  input  logic                    wo_wen_i,
  input  logic [ADDR_WIDTH-1:0]   wo_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                    wo_gnt_o,
  output logic                    wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]   wo_rdata_o,
  output logic                    l2_req_o,
  output logic                    l2_wen_o,
  output logic [ADDR_WIDTH-1:0]   l2_addr_o,
  output logic [DATA_WIDTH/8-1:0] l2_be_o,
  output logic [DATA_WIDTH-1:0]   l2_wdata_o,
  input  logic                    l2_gnt_i,
  input  logic                    l2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   l2_rdata_i,
  output logic [STAT_WIDTH-1:0]   stat_ro_gnt_o,
  output logic [STAT_WIDTH-1:0]   stat_wo_gnt_o,
  output logic [STAT_WIDTH-1:0]   stat_stall_o,
  output logic                    err_orphan_rsp_o
);

  l2_src_e sel_s;
  l2_src_e prio_r;
  l2_src_e lock_src_r;
  logic    lock_r;
  logic    err_r;
  logic    hs_s;
  logic    full_s;
  logic    empty_s;
  logic    head_s;
  logic    rsp_s;

  // Source selection: an ungranted request keeps its port until the handshake.
  always_comb begin
    sel_s = SRC_RO;
    if (lock_r) begin
      sel_s = lock_src_r;
    end else if (ro_req_i & wo_req_i) begin
      sel_s = prio_r;
    end else if (wo_req_i) begin
      sel_s = SRC_WO;
    end else begin
      sel_s = SRC_RO;
    end
  end

  assign l2_req_o   = sys_resetn_i & (ro_req_i | wo_req_i) & ~full_s;
  assign hs_s       = l2_req_o & l2_gnt_i;
  assign ro_gnt_o   = hs_s & (sel_s == SRC_RO);
  assign wo_gnt_o   = hs_s & (sel_s == SRC_WO);
  assign l2_wen_o   = (sel_s == SRC_WO) ? wo_wen_i   : ro_wen_i;
  assign l2_addr_o  = (sel_s == SRC_WO) ? wo_addr_i  : ro_addr_i;
  assign l2_be_o    = (sel_s == SRC_WO) ? wo_be_i    : ro_be_i;
  assign l2_wdata_o = (sel_s == SRC_WO) ? wo_wdata_i : ro_wdata_i;

  // A response with nothing outstanding is dropped and flagged instead of popped.
  assign rsp_s            = sys_resetn_i & l2_rvalid_i & ~empty_s;
  assign ro_rvalid_o      = rsp_s & (head_s == SRC_RO);
  assign wo_rvalid_o      = rsp_s & (head_s == SRC_WO);
  assign ro_rdata_o       = l2_rdata_i;
  assign wo_rdata_o       = l2_rdata_i;
  assign err_orphan_rsp_o = err_r;

  // Round-robin priority, request lock and sticky orphan-response flag.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_resetn_i) begin
      prio_r     <= SRC_RO;
      lock_r     <= 1'b0;
      lock_src_r <= SRC_RO;
      err_r      <= 1'b0;
    end else begin
      if (hs_s) begin
        prio_r <= other_src(sel_s);
        lock_r <= 1'b0;
      end else if (l2_req_o) begin
        lock_r     <= 1'b1;
        lock_src_r <= sel_s;
      end
      if (l2_rvalid_i & empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  udma_l2_arb_src_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk    (sys_clk_i),
    .resetn (sys_resetn_i),
    .push   (hs_s),
    .pop    (rsp_s),
    .din    (sel_s),
    .full   (full_s),
    .empty  (empty_s),
    .head   (head_s)
  );

`ifdef UDMA_L2_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_ro_r;
  logic [STAT_WIDTH-1:0] stat_wo_r;
  logic [STAT_WIDTH-1:0] stat_stall_r;
  logic                  stall_s;

  assign stall_s       = (ro_req_i | wo_req_i) & ~hs_s;
  assign stat_ro_gnt_o = stat_ro_r;
  assign stat_wo_gnt_o = stat_wo_r;
  assign stat_stall_o  = stat_stall_r;

  // Saturating handshake and stall counters.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_resetn_i) begin
      stat_ro_r    <= {STAT_WIDTH{1'b0}};
      stat_wo_r    <= {STAT_WIDTH{1'b0}};
      stat_stall_r <= {STAT_WIDTH{1'b0}};
    end else begin
      if (ro_gnt_o & ~&stat_ro_r) begin
        stat_ro_r <= stat_ro_r + STAT_WIDTH'(1);
      end
      if (wo_gnt_o & ~&stat_wo_r) begin
        stat_wo_r <= stat_wo_r + STAT_WIDTH'(1);
      end
      if (stall_s & ~&stat_stall_r) begin
        stat_stall_r <= stat_stall_r + STAT_WIDTH'(1);
      end
    end
  end
`else
  assign stat_ro_gnt_o = {STAT_WIDTH{1'b0}};
  assign stat_wo_gnt_o = {STAT_WIDTH{1'b0}};
  assign stat_stall_o  = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/udma_l2_arbiter.md
# udma_l2_arbiter

Arbitrates the uDMA subsystem's two L2 TCDM ports, the read-only (RO, TX channels) and write-only (WO, RX channels), onto a single TCDM master port toward L2. It is used where only one L2 bank port is available. It sits between `udma_subsystem` and the L2 interconnect or `tcdm_model`. It provides round-robin arbitration, request locking until grant, and in-order response routing through a source-tracking FIFO.

## Interface
- `ADDR_WIDTH`, 32: address width of all ports.
- `DATA_WIDTH`, 32: data width; byte enables are `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 4: number of granted transactions awaiting `rvalid`; power of two, minimum 2.
- `STAT_WIDTH`, 16: width of the statistics counters.

Ports:
- `sys_clk_i`  in  1  the single clock.
- `sys_resetn_i`  in  1  reset, synchronous and active-low.
- `ro_req_i`, `ro_wen_i`, `ro_addr_i`, `ro_be_i`, `ro_wdata_i`  in  1/1/ADDR_WIDTH/DATA_WIDTH/8/DATA_WIDTH  RO requester.
- `ro_gnt_o`, `ro_rvalid_o`  out  1  RO grant and response valid.
- `ro_rdata_o`  out  DATA_WIDTH  RO response data.
- `wo_*`  same set as `ro_*`  WO requester.
- `l2_req_o`, `l2_wen_o`, `l2_addr_o`, `l2_be_o`, `l2_wdata_o`  out  as above  master request.
- `l2_gnt_i`, `l2_rvalid_i`  in  1  master grant and response valid.
- `l2_rdata_i`  in  DATA_WIDTH  master response data.
- `stat_ro_gnt_o`, `stat_wo_gnt_o`, `stat_stall_o`  out  STAT_WIDTH  statistics counters (see Configuration).
- `err_orphan_rsp_o`  out  1  sticky flag: `l2_rvalid_i` arrived while no transaction was outstanding.

## Operation
- TCDM protocol on all ports:
  - A request is held until it is granted; the handshake is `req & gnt`.
  - Exactly one `rvalid` is returned per handshake, for reads and writes alike.
  - Responses arrive in order, at the earliest one cycle after the grant.
- Selection, combinational:
  - Only one port requesting: that port is selected.
  - Both ports requesting: the port indicated by `prio_q` is selected.
  - `lock_q` set: the locked source `lock_src_q` is selected unconditionally.
- `l2_req_o = (ro_req_i | wo_req_i) & ~full`. The address, wen, be and wdata outputs are muxed from the selected port.
- `x_gnt_o = l2_gnt_i & l2_req_o & (sel == x)`. A non-selected port is never granted.
- Lock:
  - Set when `l2_req_o & ~l2_gnt_i`, capturing `sel` into `lock_src_q`.
  - Cleared on the handshake.
- Round-robin: on each handshake, `prio_q` is set to the port that did not win.
- Source FIFO:
  - Each handshake pushes `sel` (`SRC_RO`/`SRC_WO`).
  - Each `l2_rvalid_i` pops the head and asserts `rvalid_o` only on the port recorded at the head.
  - `l2_rdata_i` is broadcast to both `rdata_o`.
- FIFO full: `l2_req_o` is forced to 0, including in a cycle where a pop also occurs. The lock is retained.
- FIFO empty with `l2_rvalid_i`: no pop, no `rvalid_o` on either port, and `err_orphan_rsp_o` is set. The flag clears only on reset.

## Timing
- The request path is zero latency (combinational). The response path is zero latency, `l2_rvalid_i` to `x_rvalid_o`.
- Reset values:
  - `prio_q` = RO; `lock_q` = 0; FIFO empty; counters 0; `err_orphan_rsp_o` = 0.
  - All `gnt_o` and `rvalid_o` outputs are 0 while `sys_resetn_i` is low.
  - `l2_req_o` = 0 while `sys_resetn_i` is low.
- Reset mid-transaction: outstanding entries are discarded. Later `l2_rvalid_i` pulses are treated as orphans.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged and ordering is preserved.
- Pointers wrap modulo `MAX_OUTSTANDING`. Occupancy is `$clog2(MAX_OUTSTANDING)+1` bits wide.

## Configuration
- `UDMA_L2_ARB_STATS_EN` defined:
  - `stat_ro_gnt_o` and `stat_wo_gnt_o` count handshakes per port.
  - `stat_stall_o` counts cycles with any request pending and no handshake.
  - All counters saturate at all-ones.
- Not defined: the counters are not implemented and the outputs are tied to 0. Arbitration behaviour is identical in both cases.

## Structure
- Package `udma_l2_arb_pkg`:
  - `typedef enum logic {SRC_RO, SRC_WO} l2_src_e`.
  - Default localparams for the width parameters.
- Sub-module `udma_l2_arb_src_fifo`: 1-bit wide, `MAX_OUTSTANDING` deep, providing push/pop/full/empty/head.

## Test plan
- Single read: RO reads `0x100`, memory grants immediately, `rvalid` returns 1 cycle later → `ro_rvalid_o` pulses once, `ro_rdata_o` equals the memory word, `wo_rvalid_o` stays 0.
- Contention: RO and WO request continuously with grants always given → grants alternate RO, WO, RO, WO… starting with RO after reset; each counter reaches 4 after 8 handshakes.
- Lock: both request, `l2_gnt_i` is held low for 3 cycles → the selected port and `l2_addr_o` stay stable for all 3 cycles; the other port is not granted until the handshake.
- Outstanding limit: `MAX_OUTSTANDING` = 4, 4 grants are given with `rvalid` withheld → `l2_req_o` drops to 0; it is re-asserted the cycle after the first `rvalid`; responses route as RO, WO, RO, WO in grant order.
- Orphan and reset: `l2_rvalid_i` is pulsed with the FIFO empty → `err_orphan_rsp_o` = 1 and no port `rvalid_o`. Then `sys_resetn_i` is held low for 1 cycle with 2 transactions outstanding → the flag clears, the FIFO is empty, and `prio_q` returns to RO.
